// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order dispatch, out-of-order write-back on
// WB_PORTS ports, in-order retirement with store handshake and flush on redirect.
module rob_param #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned IDX_W    = $clog2(DEPTH),
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned WB_PORTS = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         rdy_in,
  input  logic                         disp_valid_in,
  output logic                         disp_ready_out,
  input  logic [1:0]                   disp_kind_in,
  input  logic [REG_W-1:0]             disp_rd_in,
  input  logic [1:0]                   disp_size_in,
  output logic [IDX_W-1:0]             disp_tag_out,
  input  logic [IDX_W-1:0]             disp_q1_in,
  input  logic [IDX_W-1:0]             disp_q2_in,
  output logic                         q1_rdy_out,
  output logic                         q2_rdy_out,
  output logic [DATA_W-1:0]            q1_data_out,
  output logic [DATA_W-1:0]            q2_data_out,
  input  logic [WB_PORTS-1:0]          wb_valid_in,
  input  logic [WB_PORTS*IDX_W-1:0]    wb_tag_in,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_value_in,
  input  logic [WB_PORTS*32-1:0]       wb_addr_in,
  input  logic [WB_PORTS-1:0]          wb_redirect_in,
  output logic                         commit_valid_out,
  output logic [REG_W-1:0]             commit_rd_out,
  output logic [IDX_W-1:0]             commit_tag_out,
  output logic [DATA_W-1:0]            commit_value_out,
  output logic                         st_valid_out,
  input  logic                         st_ready_in,
  output logic [31:0]                  st_addr_out,
  output logic [DATA_W-1:0]            st_data_out,
  output logic [1:0]                   st_size_out,
  output logic                         flush_out,
  output logic [31:0]                  redirect_pc_out,
  output logic [IDX_W:0]               count_out
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [1:0] K_REG = 2'd0;
  localparam logic [1:0] K_BR  = 2'd1;
  localparam logic [1:0] K_ST  = 2'd2;
  localparam logic [1:0] K_JMP = 2'd3;

  typedef enum logic {S_IDLE, S_REQ} st_state_e;

  logic [DEPTH-1:0]  busy_q, busy_d, done_q, done_d, redir_q;
  logic [1:0]        kind_q  [DEPTH];
  logic [REG_W-1:0]  rd_q    [DEPTH];
  logic [1:0]        size_q  [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [31:0]       addr_q  [DEPTH];

  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  st_state_e         st_state_q;

  logic              commit_valid_q, flush_q, st_valid_q;
  logic [REG_W-1:0]  commit_rd_q;
  logic [IDX_W-1:0]  commit_tag_q;
  logic [DATA_W-1:0] commit_value_q, st_data_q;
  logic [31:0]       redirect_pc_q, st_addr_q;
  logic [1:0]        st_size_q;

  logic              full, disp_fire, retire_ok, st_pop, st_start, pop, flush, commit;
  logic [1:0]        head_kind;
  logic [IDX_W-1:0]  wb_tag [WB_PORTS];
  logic [WB_PORTS-1:0] wb_hit;

  // Retire decision on the head entry; a store parks the FSM until memory accepts.
  assign full           = (count_q == CNT_W'(DEPTH));
  assign disp_ready_out = !full && !flush_q;
  assign disp_fire      = rdy_in && disp_valid_in && disp_ready_out;
  assign head_kind      = kind_q[head_q];
  assign retire_ok      = rdy_in && (st_state_q == S_IDLE) && busy_q[head_q] && done_q[head_q];
  assign st_pop         = rdy_in && (st_state_q == S_REQ) && st_ready_in;
  assign st_start       = retire_ok && (head_kind == K_ST);
  assign flush          = retire_ok && ((head_kind == K_JMP) ||
                                        ((head_kind == K_BR) && redir_q[head_q]));
  assign commit         = retire_ok && ((head_kind == K_REG) || (head_kind == K_JMP));
  assign pop            = st_pop || (retire_ok && ((head_kind == K_REG) ||
                                        ((head_kind == K_BR) && !redir_q[head_q])));

  always_comb begin
    for (int unsigned p = 0; p < WB_PORTS; p++) begin
      wb_tag[p] = wb_tag_in[p*IDX_W +: IDX_W];
      wb_hit[p] = rdy_in && !flush && wb_valid_in[p] && busy_q[wb_tag[p]];
    end
  end

  // Occupancy bookkeeping; a flush overrides every other update this edge.
  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int unsigned p = 0; p < WB_PORTS; p++) begin
        if (wb_hit[p]) done_d[wb_tag[p]] = 1'b1;
      end
      if (pop) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + IDX_W'(1);
      end
      if (disp_fire) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        tail_d         = tail_q + IDX_W'(1);
      end
      count_d = count_q + CNT_W'(disp_fire) - CNT_W'(pop);
    end
  end

  // Operand lookup: stored result wins, else the lowest-index forwarding port.
  always_comb begin
    q1_rdy_out  = done_q[disp_q1_in];
    q2_rdy_out  = done_q[disp_q2_in];
    q1_data_out = '0;
    q2_data_out = '0;
    for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
      if (wb_valid_in[p] && (wb_tag[p] == disp_q1_in)) begin
        q1_rdy_out  = 1'b1;
        q1_data_out = wb_value_in[p*DATA_W +: DATA_W];
      end
      if (wb_valid_in[p] && (wb_tag[p] == disp_q2_in)) begin
        q2_rdy_out  = 1'b1;
        q2_data_out = wb_value_in[p*DATA_W +: DATA_W];
      end
    end
    if (done_q[disp_q1_in]) q1_data_out = value_q[disp_q1_in];
    if (done_q[disp_q2_in]) q2_data_out = value_q[disp_q2_in];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q         <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      st_state_q     <= S_IDLE;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_tag_q   <= '0;
      commit_value_q <= '0;
      flush_q        <= 1'b0;
      redirect_pc_q  <= '0;
      st_valid_q     <= 1'b0;
      st_addr_q      <= '0;
      st_data_q      <= '0;
      st_size_q      <= '0;
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit;
      flush_q        <= flush;
      if (commit) begin
        commit_rd_q    <= rd_q[head_q];
        commit_tag_q   <= head_q;
        commit_value_q <= value_q[head_q];
      end
      if (flush) redirect_pc_q <= addr_q[head_q];
      case (st_state_q)
        S_IDLE: if (st_start) begin
          st_state_q <= S_REQ;
          st_valid_q <= 1'b1;
          st_addr_q  <= addr_q[head_q];
          st_data_q  <= value_q[head_q];
          st_size_q  <= size_q[head_q];
        end
        S_REQ: if (st_pop) begin
          st_state_q <= S_IDLE;
          st_valid_q <= 1'b0;
        end
        default: st_state_q <= S_IDLE;
      endcase
    end
  end

  // Entry payload needs no reset: it is only observed once busy/done say so.
  always_ff @(posedge clk_in) begin
    if (disp_fire && !flush) begin
      kind_q[tail_q]  <= disp_kind_in;
      rd_q[tail_q]    <= disp_rd_in;
      size_q[tail_q]  <= disp_size_in;
      redir_q[tail_q] <= 1'b0;
    end
    for (int unsigned p = 0; p < WB_PORTS; p++) begin
      if (wb_hit[p]) begin
        value_q[wb_tag[p]] <= wb_value_in[p*DATA_W +: DATA_W];
        addr_q[wb_tag[p]]  <= wb_addr_in[p*32 +: 32];
        redir_q[wb_tag[p]] <= wb_redirect_in[p];
      end
    end
  end

  assign disp_tag_out     = tail_q;
  assign commit_valid_out = commit_valid_q;
  assign commit_rd_out    = commit_rd_q;
  assign commit_tag_out   = commit_tag_q;
  assign commit_value_out = commit_value_q;
  assign flush_out        = flush_q;
  assign redirect_pc_out  = redirect_pc_q;
  assign st_valid_out     = st_valid_q;
  assign st_addr_out      = st_addr_q;
  assign st_data_out      = st_data_q;
  assign st_size_out      = st_size_q;
  assign count_out        = count_q;

endmodule
